arbitro_memoria_dados: RTL and testbench
========================================

# arbitro_memoria_dados

Two-port arbiter and sequencer for the 8-bit, 256-entry data memory (write on rising edge, read on falling edge). Shares the single memory port between requester 0 (processor load/store path) and requester 1 (loader/debug port): selects one request, drives address, write data and the write/read strobes for exactly one cycle, and returns an acknowledge plus read data. Sits between the requesters and the data memory instance; it is the only block driving the memory control inputs.

## Interface
- PRIORIDADE_FIXA, 0, 0 = round-robin between ports; 1 = port 0 always wins ties
- LARG, 8, address/data width; memory depth is 2^LARG

- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- Req0  in  1  port 0 request; held with Esc0/End0/Dado0 stable until Ack0
- Esc0  in  1  port 0 operation: 1 = write, 0 = read
- End0  in  LARG  port 0 address
- Dado0  in  LARG  port 0 write data
- Ack0  out  1  one-cycle completion pulse for port 0
- Req1, Esc1, End1, Dado1, Ack1: same as port 0, for port 1
- DadoLido  out  LARG  read result; valid when the corresponding Ack is high for a read, held until the next read completes
- Endereco  out  LARG  memory address
- DadoEscritoMem  out  LARG  memory write data
- EscMem  out  1  memory write strobe
- LerMem  out  1  memory read strobe
- DadoLidoMem  in  LARG  memory read data
- Ocupado  out  1  high in ACESSO and RESPOSTA

## Operation
- FSM states: OCIOSO, ACESSO, RESPOSTA.
- OCIOSO: if any Req is high at the rising edge, pick winner, register its address, data and strobe (EscMem = Esc, LerMem = ~Esc), store winner id, go to ACESSO. No request: stay; all strobes 0.
- ACESSO (one cycle): strobes stable all cycle; memory reads on the falling edge and writes on the next rising edge. At that edge: clear EscMem/LerMem; for a read, capture DadoLidoMem into DadoLido; raise winner's Ack; go to RESPOSTA.
- RESPOSTA (one cycle): Ack high; requests are not sampled; next edge clears Ack and goes to OCIOSO.
- Selection: only one Req high -> that port. Both high: PRIORIDADE_FIXA=1 -> port 0; else the port not served last. The last-served register updates only on entry to ACESSO; reset value = port 1, so port 0 wins the first tie.
- Endereco/DadoEscritoMem keep their last value outside ACESSO; only the strobes are qualified.
- Esc=1 never raises LerMem; both strobes are never high together.
- Addresses use full LARG bits; no wrap or range check is needed.

## Timing
- Reset values: EscMem=0, LerMem=0, Ack0=0, Ack1=0, Ocupado=0, Endereco=0, DadoEscritoMem=0, DadoLido=0, state OCIOSO, last-served=1.
- Request sampled at edge E0. Strobes are high during cycle E0–E1. Write commits at E1. Ack is high during E1–E2. Back in OCIOSO from E2, and the next request is sampled at E3 at the earliest.
- Throughput: one access per 3 cycles. Latency from the sampling edge to Ack: 1 cycle.
- The requester may keep Req high after Ack for a back-to-back transaction. The new operands must be stable by E3.
- A loser keeps Req high and is served in the next arbitration. With round-robin, waiting is bounded by one access of the other port.
- Reset during ACESSO: strobes drop asynchronously before E1, so the write is aborted and memory is unchanged. No Ack is issued. Reset during RESPOSTA: Ack drops immediately.
- Req deasserted before Ack: undefined for the requester; the arbiter still completes the already-latched access.

## Structure
- Shared package: LARG default, state encoding (OCIOSO/ACESSO/RESPOSTA), port id constants (PORTA0=0, PORTA1=1).
- Sub-module seletor_rr: combinational winner select from Req0, Req1, last-served and PRIORIDADE_FIXA; outputs grant-valid and winner id. The FSM and registers stay in arbitro_memoria_dados.

## Test plan
- Reset, then port 0 writes 0xA5 to address 0x10. Expect EscMem=1 for exactly one cycle with Endereco=0x10, then Ack0 one cycle later. Port 0 then reads 0x10: DadoLido=0xA5 with Ack0, and LerMem was never high during the write.
- Both ports request in the same cycle with round-robin, port 0 reading 0x01 and port 1 writing 0x3C to 0x02, both held high. Expect port 0 served first, then port 1 (Ack1 three cycles after Ack0). Repeat the tie: port 1 is not starved and grants alternate.
- PRIORIDADE_FIXA=1 with both Req held high for 4 transactions. Expect only Ack0 to pulse, and port 1 is served once Req0 drops.
- Port 1 reads address 0xFF preloaded with 0x7E. Expect DadoLido=0x7E, Endereco=0xFF, and Ack0 stays 0.
- Port 0 writes 0x55 to 0x20 and Reset is pulsed mid-ACESSO before the rising edge. Expect strobes and Ack at 0 at once, memory[0x20] unchanged, and the FSM in OCIOSO.
- Port 0 keeps Req0 high for back-to-back reads of 0x00..0x03. Expect Ack0 every 3 cycles, returning data in address order.

Source files
------------

// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared definitions for the data-memory arbiter: default width, FSM states and port ids.
package arbitro_memoria_dados_pkg;

  localparam int unsigned LARG_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam logic PORTA0 = 1'b0;
  localparam logic PORTA1 = 1'b1;

endpackage

// File: rtl/arbitro_memoria_dados_seletor_rr.sv
// Combinational winner selection between the two requesters (fixed priority or round-robin).
module arbitro_memoria_dados_seletor_rr
  import arbitro_memoria_dados_pkg::*;
#(
  parameter bit PRIORIDADE_FIXA = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic ultimo,
  output logic valido_c,
  output logic vencedor_c
);

  // On a tie, round-robin hands the grant to the port not served last.
  always_comb begin
    valido_c   = req0 | req1;
    vencedor_c = PORTA0;
    if (req0 && req1) begin
      vencedor_c = PRIORIDADE_FIXA ? PORTA0 : ~ultimo;
    end else if (req1) begin
      vencedor_c = PORTA1;
    end
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter/sequencer for the shared data memory: one strobed access per grant,
// followed by a one-cycle acknowledge to the winning port.
module arbitro_memoria_dados
  import arbitro_memoria_dados_pkg::*;
#(
  parameter bit          PRIORIDADE_FIXA = 1'b0,
  parameter int unsigned LARG            = LARG_PADRAO
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Req0,
  input  logic            Esc0,
  input  logic [LARG-1:0] End0,
  input  logic [LARG-1:0] Dado0,
  output logic            Ack0,
  input  logic            Req1,
  input  logic            Esc1,
  input  logic [LARG-1:0] End1,
  input  logic [LARG-1:0] Dado1,
  output logic            Ack1,
  output logic [LARG-1:0] DadoLido,
  output logic [LARG-1:0] Endereco,
  output logic [LARG-1:0] DadoEscritoMem,
  output logic            EscMem,
  output logic            LerMem,
  input  logic [LARG-1:0] DadoLidoMem,
  output logic            Ocupado
);

  estado_t estado;
  logic    ultimo;
  logic    valido_c;
  logic    vencedor_c;

  arbitro_memoria_dados_seletor_rr #(
    .PRIORIDADE_FIXA(PRIORIDADE_FIXA)
  ) seletor_rr (
    .req0      (Req0),
    .req1      (Req1),
    .ultimo    (ultimo),
    .valido_c  (valido_c),
    .vencedor_c(vencedor_c)
  );

  // ultimo doubles as the id of the port currently being served.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado         <= OCIOSO;
      ultimo         <= PORTA1;
      Ack0           <= 1'b0;
      Ack1           <= 1'b0;
      DadoLido       <= '0;
      Endereco       <= '0;
      DadoEscritoMem <= '0;
      EscMem         <= 1'b0;
      LerMem         <= 1'b0;
      Ocupado        <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido_c) begin
            estado  <= ACESSO;
            ultimo  <= vencedor_c;
            Ocupado <= 1'b1;
            if (vencedor_c == PORTA1) begin
              Endereco       <= End1;
              DadoEscritoMem <= Dado1;
              EscMem         <= Esc1;
              LerMem         <= ~Esc1;
            end else begin
              Endereco       <= End0;
              DadoEscritoMem <= Dado0;
              EscMem         <= Esc0;
              LerMem         <= ~Esc0;
            end
          end
        end
        ACESSO: begin
          // Memory read data settled on the falling edge; the write commits on this edge.
          EscMem <= 1'b0;
          LerMem <= 1'b0;
          if (LerMem) begin
            DadoLido <= DadoLidoMem;
          end
          Ack0   <= (ultimo == PORTA0);
          Ack1   <= (ultimo == PORTA1);
          estado <= RESPOSTA;
        end
        RESPOSTA: begin
          Ack0    <= 1'b0;
          Ack1    <= 1'b0;
          Ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the arbiter and memory.
module tb_arbitro_memoria_dados;

  logic       Clock;
  logic       Reset;
  logic       Req0, Esc0, Req1, Esc1;
  logic [7:0] End0, Dado0, End1, Dado1;

  logic       ack0_rr, ack1_rr, esc_mem_rr, ler_mem_rr, ocupado_rr;
  logic [7:0] lido_rr, end_rr, dado_esc_rr, lido_mem_rr;
  logic       ack0_fx, ack1_fx, esc_mem_fx, ler_mem_fx, ocupado_fx;
  logic [7:0] lido_fx, end_fx, dado_esc_fx, lido_mem_fx;

  logic [7:0] mem_rr [256];
  logic [7:0] mem_fx [256];
  logic [7:0] modelo [256];
  logic       pre;

  int checks;
  int failures;
  int violacoes;
  int ciclo;

  typedef struct {
    logic       porta;
    logic       esc;
    logic [7:0] endr;
    logic [7:0] dado;
    logic [7:0] lido;
  } vetor_t;

  arbitro_memoria_dados #(.PRIORIDADE_FIXA(1'b0), .LARG(8)) dut_rr (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Esc0(Esc0), .End0(End0), .Dado0(Dado0), .Ack0(ack0_rr),
    .Req1(Req1), .Esc1(Esc1), .End1(End1), .Dado1(Dado1), .Ack1(ack1_rr),
    .DadoLido(lido_rr), .Endereco(end_rr), .DadoEscritoMem(dado_esc_rr),
    .EscMem(esc_mem_rr), .LerMem(ler_mem_rr), .DadoLidoMem(lido_mem_rr),
    .Ocupado(ocupado_rr)
  );

  arbitro_memoria_dados #(.PRIORIDADE_FIXA(1'b1), .LARG(8)) dut_fx (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Esc0(Esc0), .End0(End0), .Dado0(Dado0), .Ack0(ack0_fx),
    .Req1(Req1), .Esc1(Esc1), .End1(End1), .Dado1(Dado1), .Ack1(ack1_fx),
    .DadoLido(lido_fx), .Endereco(end_fx), .DadoEscritoMem(dado_esc_fx),
    .EscMem(esc_mem_fx), .LerMem(ler_mem_fx), .DadoLidoMem(lido_mem_fx),
    .Ocupado(ocupado_fx)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [7:0] valor_inicial(input int i);
    if (i == 255) return 8'h7E;
    if (i == 32) return 8'h11;
    return 8'(i * 37 + 11);
  endfunction

  // Memory models: write on rising edge, read on falling edge.
  always @(posedge Clock) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) begin
        mem_rr[i] <= valor_inicial(i);
        mem_fx[i] <= valor_inicial(i);
      end
    end else begin
      if (esc_mem_rr) mem_rr[end_rr] <= dado_esc_rr;
      if (esc_mem_fx) mem_fx[end_fx] <= dado_esc_fx;
    end
  end

  always @(negedge Clock) begin
    if (ler_mem_rr) lido_mem_rr <= mem_rr[end_rr];
    if (ler_mem_fx) lido_mem_fx <= mem_fx[end_fx];
  end

  initial violacoes = 0;
  always @(negedge Clock) begin
    if ((esc_mem_rr && ler_mem_rr) || (esc_mem_fx && ler_mem_fx) ||
        (ack0_rr && ack1_rr) || (ack0_fx && ack1_fx))
      violacoes++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: atual=0x%0h esperado=0x%0h", nome, atual, esperado);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    ciclo++;
  endtask

  task automatic pedir(input logic p, input logic e, input logic [7:0] a, input logic [7:0] d);
    if (p) begin
      Req1 = 1'b1; Esc1 = e; End1 = a; Dado1 = d;
    end else begin
      Req0 = 1'b1; Esc0 = e; End0 = a; Dado0 = d;
    end
  endtask

  task automatic soltar(input logic p);
    if (p) Req1 = 1'b0;
    else   Req0 = 1'b0;
  endtask

  task automatic reiniciar();
    Req0 = 1'b0; Req1 = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Single isolated access on the round-robin DUT with exact cycle timing.
  task automatic acesso_unico(input vetor_t v);
    pedir(v.porta, v.esc, v.endr, v.dado);
    tick();
    chk("strobe_esc", 32'(esc_mem_rr), 32'(v.esc));
    chk("strobe_ler", 32'(ler_mem_rr), 32'(!v.esc));
    chk("endereco", 32'(end_rr), 32'(v.endr));
    chk("ocupado_acesso", 32'(ocupado_rr), 32'd1);
    if (v.esc) chk("dado_escrito", 32'(dado_esc_rr), 32'(v.dado));
    tick();
    chk("ack0", 32'(ack0_rr), 32'(v.porta == 1'b0));
    chk("ack1", 32'(ack1_rr), 32'(v.porta == 1'b1));
    chk("strobes_apos", 32'({esc_mem_rr, ler_mem_rr}), 32'd0);
    if (!v.esc) chk("dado_lido", 32'(lido_rr), 32'(v.lido));
    else modelo[v.endr] = v.dado;
    soltar(v.porta);
    tick();
    chk("ack_fim", 32'({ack0_rr, ack1_rr}), 32'd0);
  endtask

  vetor_t tabela [6];
  int     ack_ciclo [$];
  logic   ack_porta [$];
  int     n0, n1;
  logic   achou;
  logic   ultimo_m;
  logic   pend [2];
  logic   op_e [2];
  logic [7:0] op_a [2];
  logic [7:0] op_d [2];
  logic   esperado;

  initial begin
    checks = 0; failures = 0; ciclo = 0;
    Req0 = 0; Esc0 = 0; End0 = 0; Dado0 = 0;
    Req1 = 0; Esc1 = 0; End1 = 0; Dado1 = 0;
    for (int i = 0; i < 256; i++) modelo[i] = valor_inicial(i);
    pre = 1'b1;
    Reset = 1'b1;
    tick();
    tick();
    pre = 1'b0;

    chk("reset_escmem", 32'(esc_mem_rr), 32'd0);
    chk("reset_lermem", 32'(ler_mem_rr), 32'd0);
    chk("reset_acks", 32'({ack0_rr, ack1_rr}), 32'd0);
    chk("reset_ocupado", 32'(ocupado_rr), 32'd0);
    chk("reset_endereco", 32'(end_rr), 32'd0);
    chk("reset_dado_escrito", 32'(dado_esc_rr), 32'd0);
    chk("reset_dado_lido", 32'(lido_rr), 32'd0);
    Reset = 1'b0;
    tick();

    tabela[0] = '{porta: 1'b0, esc: 1'b1, endr: 8'h10, dado: 8'hA5, lido: 8'h00};
    tabela[1] = '{porta: 1'b0, esc: 1'b0, endr: 8'h10, dado: 8'h00, lido: 8'hA5};
    tabela[2] = '{porta: 1'b1, esc: 1'b0, endr: 8'hFF, dado: 8'h00, lido: 8'h7E};
    tabela[3] = '{porta: 1'b1, esc: 1'b1, endr: 8'h30, dado: 8'h66, lido: 8'h00};
    tabela[4] = '{porta: 1'b0, esc: 1'b0, endr: 8'h30, dado: 8'h00, lido: 8'h66};
    tabela[5] = '{porta: 1'b1, esc: 1'b0, endr: 8'h10, dado: 8'h00, lido: 8'hA5};
    for (int i = 0; i < 6; i++) acesso_unico(tabela[i]);

    // Round-robin tie with both requests held: grants alternate, 3 cycles apart.
    reiniciar();
    pedir(1'b0, 1'b0, 8'h01, 8'h00);
    pedir(1'b1, 1'b1, 8'h02, 8'h3C);
    ack_ciclo.delete();
    ack_porta.delete();
    for (int c = 0; c < 20 && ack_porta.size() < 4; c++) begin
      tick();
      if (ack0_rr) begin
        if (ack_porta.size() == 0) chk("rr_dado_lido", 32'(lido_rr), 32'(modelo[1]));
        ack_porta.push_back(1'b0);
        ack_ciclo.push_back(ciclo);
      end
      if (ack1_rr) begin
        ack_porta.push_back(1'b1);
        ack_ciclo.push_back(ciclo);
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    modelo[2] = 8'h3C;
    chk("rr_qtd_acks", 32'(ack_porta.size()), 32'd4);
    for (int i = 0; i < ack_porta.size(); i++) begin
      chk("rr_ordem", 32'(ack_porta[i]), 32'(i % 2));
      if (i > 0) chk("rr_intervalo", 32'(ack_ciclo[i] - ack_ciclo[i-1]), 32'd3);
    end
    tick();
    chk("rr_mem_02", 32'(mem_rr[2]), 32'h3C);

    // Fixed priority: port 0 wins every tie; port 1 served once Req0 drops.
    reiniciar();
    pedir(1'b0, 1'b0, 8'h01, 8'h00);
    pedir(1'b1, 1'b0, 8'hFF, 8'h00);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack0_fx) n0++;
      if (ack1_fx) n1++;
    end
    chk("fx_acks0", 32'(n0), 32'd4);
    chk("fx_acks1", 32'(n1), 32'd0);
    Req0 = 1'b0;
    achou = 1'b0;
    n0 = 0;
    for (int c = 0; c < 8 && !achou; c++) begin
      tick();
      if (ack0_fx) n0++;
      if (ack1_fx) achou = 1'b1;
    end
    chk("fx_porta1_servida", 32'(achou), 32'd1);
    chk("fx_sem_ack0", 32'(n0), 32'd0);
    chk("fx_dado_lido", 32'(lido_fx), 32'h7E);
    Req1 = 1'b0;

    // Reset in the middle of ACESSO aborts the write without an Ack.
    reiniciar();
    pedir(1'b0, 1'b1, 8'h20, 8'h55);
    tick();
    chk("rst_escmem_antes", 32'(esc_mem_rr), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    chk("rst_strobes", 32'({esc_mem_rr, ler_mem_rr}), 32'd0);
    chk("rst_ack", 32'({ack0_rr, ack1_rr}), 32'd0);
    chk("rst_ocupado", 32'(ocupado_rr), 32'd0);
    Req0 = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_mem_20", 32'(mem_rr[32]), 32'(modelo[32]));
    tick();
    chk("rst_ocioso", 32'(ocupado_rr), 32'd0);
    acesso_unico('{porta: 1'b0, esc: 1'b0, endr: 8'h20, dado: 8'h00, lido: 8'h11});

    // Back-to-back reads of 0x00..0x03 with Req0 held.
    ack_ciclo.delete();
    pedir(1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      achou = 1'b0;
      for (int c = 0; c < 8 && !achou; c++) begin
        tick();
        if (ack0_rr) achou = 1'b1;
      end
      chk("b2b_ack", 32'(achou), 32'd1);
      chk("b2b_dado", 32'(lido_rr), 32'(modelo[k]));
      ack_ciclo.push_back(ciclo);
      End0 = 8'(k + 1);
    end
    Req0 = 1'b0;
    for (int i = 1; i < ack_ciclo.size(); i++)
      chk("b2b_intervalo", 32'(ack_ciclo[i] - ack_ciclo[i-1]), 32'd3);

    // Randomized traffic against a transaction-level model.
    reiniciar();
    ultimo_m = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 120; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          op_e[p] = 1'($urandom_range(0, 1));
          op_a[p] = 8'($urandom);
          op_d[p] = 8'($urandom);
          pend[p] = 1'b1;
          pedir(1'(p), op_e[p], op_a[p], op_d[p]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        tick();
        continue;
      end
      esperado = (pend[0] && pend[1]) ? ~ultimo_m : pend[1];
      achou = 1'b0;
      for (int c = 0; c < 8 && !achou; c++) begin
        tick();
        if (ack0_rr || ack1_rr) achou = 1'b1;
      end
      chk("rnd_ack", 32'(achou), 32'd1);
      if (achou) begin
        chk("rnd_porta", 32'(ack1_rr), 32'(esperado));
        if (!op_e[esperado]) chk("rnd_lido", 32'(lido_rr), 32'(modelo[op_a[esperado]]));
        else modelo[op_a[esperado]] = op_d[esperado];
      end
      ultimo_m = esperado;
      pend[esperado] = 1'b0;
      soltar(esperado);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 256; i++)
      if (mem_rr[i] !== modelo[i]) chk("rnd_mem", 32'(mem_rr[i]), 32'(modelo[i]));
    chk("exclusividade", 32'(violacoes), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
